// File: rtl/key_pio_debounce.sv
// Multi-channel Avalon-MM input PIO with per-channel debounce, edge capture and masked IRQ.
// Define KEY_PIO_W1C_EN for write-1-to-clear EDGE_CAPTURE; otherwise any write clears all bits.
module key_pio_debounce #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEB_W     = 20,
    parameter int unsigned DEB_RESET = 50000,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DEB_W-1:0] PeriodRst = DEB_W'(DEB_RESET);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0]            stable_dly_q;
    logic [WIDTH-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [DEB_W-1:0]            period_q, period_d;
    logic [WIDTH-1:0]            mask_q, mask_d;
    logic [WIDTH-1:0]            cap_q, cap_d;
    logic [31:0]                 readdata_q, readdata_d;
    logic [WIDTH-1:0]            edge_det;
    logic                        wr_en;
    logic                        wr_period;
    logic                        wr_mask;
    logic                        wr_cap;
    logic                        unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_period    = wr_en && (address == 2'd1);
    assign wr_mask      = wr_en && (address == 2'd2);
    assign wr_cap       = wr_en && (address == 2'd3);
    assign unused_wdata = ^writedata;

    // Debounce: a channel adopts the synchronised level only after it has differed
    // from the stable level for `period` consecutive cycles (period 0 bypasses).
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (period_q == '0) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (cnt_q[i] == period_q - DEB_W'(1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
        // Restarting every count avoids a counter already past the new limit.
        if (wr_period) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = stable_q & ~stable_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~stable_q & stable_dly_q;
        end else begin
            edge_det = stable_q ^ stable_dly_q;
        end
    end

    always_comb begin
        period_d = period_q;
        mask_d   = mask_q;
        cap_d    = cap_q;
        if (wr_period) begin
            period_d = writedata[DEB_W-1:0];
        end
        if (wr_mask) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_cap) begin
`ifdef KEY_PIO_W1C_EN
            cap_d = cap_q & ~writedata[WIDTH-1:0];
`else
            cap_d = '0;
`endif
        end
        // A new edge overrides a clear landing in the same cycle.
        cap_d = cap_d | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0: readdata_d[WIDTH-1:0] = stable_q;
            2'd1: readdata_d[DEB_W-1:0] = period_q;
            2'd2: readdata_d[WIDTH-1:0] = mask_q;
            2'd3: readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            period_q     <= PeriodRst;
            mask_q       <= '0;
            cap_q        <= '0;
            readdata_q   <= '0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_key_pio_debounce.sv
// Self-checking bench for key_pio_debounce: directed stimulus, literal checks and a
// cycle-level behavioural model compared on every falling clock edge.
module tb_key_pio_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef KEY_PIO_W1C_EN
    localparam logic [31:0] PartialClrExp = 32'h2;
`else
    localparam logic [31:0] PartialClrExp = 32'h0;
`endif

    key_pio_debounce #(
        .WIDTH    (4),
        .DEB_W    (20),
        .DEB_RESET(50000),
        .EDGE_TYPE(0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the input has disagreed with the accepted level
    // for max(period,1) consecutive cycles after the two-stage input delay.
    typedef struct packed {
        logic [3:0]       s1;
        logic [3:0]       s2;
        logic [3:0]       stable;
        logic [3:0]       prev;
        logic [3:0]       mask;
        logic [3:0]       cap;
        logic [3:0][31:0] run;
        logic [31:0]      period;
        logic [31:0]      rd;
    } model_t;

    model_t m;

    function automatic model_t model_rst();
        model_t r;
        r        = '0;
        r.period = 32'd50000;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, logic [1:0] a, logic cs, logic wn,
                                          logic [31:0] wd, logic [3:0] pin);
        model_t n;
        logic   wr;
        int     lim;
        n   = c;
        wr  = cs && !wn;
        lim = (c.period == 0) ? 1 : int'(c.period);
        n.s1 = pin;
        n.s2 = c.s1;
        for (int i = 0; i < 4; i++) begin
            if (c.s2[i] == c.stable[i]) begin
                n.run[i] = 0;
            end else if (int'(c.run[i]) + 1 >= lim) begin
                n.stable[i] = c.s2[i];
                n.run[i]    = 0;
            end else begin
                n.run[i] = c.run[i] + 1;
            end
        end
        if (wr && a == 2'd1) begin
            n.period = wd & 32'h000F_FFFF;
            for (int i = 0; i < 4; i++) n.run[i] = 0;
        end
        if (wr && a == 2'd2) n.mask = wd[3:0];
        n.prev = c.stable;
        if (wr && a == 2'd3) begin
`ifdef KEY_PIO_W1C_EN
            n.cap = c.cap & ~wd[3:0];
`else
            n.cap = 4'h0;
`endif
        end
        n.cap = n.cap | (c.stable & ~c.prev);
        case (a)
            2'd0:    n.rd = {28'h0, c.stable};
            2'd1:    n.rd = c.period;
            2'd2:    n.rd = {28'h0, c.mask};
            default: n.rd = {28'h0, c.cap};
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_rst();
        else          m <= model_next(m, address, chipselect, write_n, writedata, in_port);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("model_readdata", readdata, m.rd);
        chk("model_irq", {31'h0, irq}, {31'h0, |(m.cap & m.mask)});
    endtask

    task automatic steps(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chk(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0000C350, "rst_period");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_cap");
        chk("rst_irq", {31'h0, irq}, 32'h0);

        // Debounce latency 2 + 4 cycles
        wr(2'd1, 32'd4);
        address = 2'd0;
        in_port = 4'b0001;
        steps(6);
        chk("data_not_early", readdata, 32'h0);
        step();
        chk("data_settled", readdata, 32'h1);
        rd(2'd3, 32'h1, "cap_ch0");
        chk("irq_masked", {31'h0, irq}, 32'h0);

        // 3-cycle glitch on channel 1 is rejected
        in_port = 4'b0011;
        steps(3);
        in_port = 4'b0001;
        steps(12);
        rd(2'd0, 32'h1, "glitch_data");
        rd(2'd3, 32'h1, "glitch_cap");

        // Masked IRQ on channel 2, then clear
        wr(2'd2, 32'hF);
        wr(2'd3, 32'hF);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        in_port = 4'b0101;
        steps(6);
        chk("irq_before_cap", {31'h0, irq}, 32'h0);
        step();
        chk("irq_after_cap", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h4);
        chk("irq_after_clr", {31'h0, irq}, 32'h0);

        // Read-during-write returns old value; period 0 bypass
        wr(2'd1, 32'd0);
        chk("rdw_old", readdata, 32'd4);
        rd(2'd1, 32'h0, "period_zero");
        address = 2'd0;
        in_port = 4'b0111;
        steps(3);
        chk("bypass_not_early", readdata, 32'h5);
        step();
        chk("bypass_data", readdata, 32'h7);

        // Partial clear: W1C keeps bit 1, legacy clears all
        in_port = 4'b0000;
        steps(5);
        wr(2'd3, 32'hF);
        in_port = 4'b0011;
        steps(5);
        rd(2'd3, 32'h3, "cap_two_bits");
        wr(2'd3, 32'h1);
        rd(2'd3, PartialClrExp, "cap_partial_clr");

        // Clear and new edge on bit 0 in the same cycle: edge wins
        in_port = 4'b0010;
        steps(5);
        wr(2'd3, 32'hF);
        in_port = 4'b0011;
        steps(3);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h1, "edge_wins");

        // Reset in the middle of a debounce
        wr(2'd1, 32'd4);
        in_port = 4'b1111;
        steps(3);
        reset_n = 1'b0;
        #1;
        chk("async_rst_readdata", readdata, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        steps(2);
        reset_n = 1'b1;
        rd(2'd0, 32'h0, "mid_rst_data");
        rd(2'd1, 32'h0000C350, "mid_rst_period");
        rd(2'd2, 32'h0, "mid_rst_mask");
        rd(2'd3, 32'h0, "mid_rst_cap");
        steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
